// File: rtl/bin_a_bcd_param_if.sv
// rtl/bin_a_bcd_param_if.sv - start/ready/valid bundle for the binary-to-BCD converter (signo_output under BCD_SIGNED_EN)
interface bin_a_bcd_param_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      numero_input;
    logic                  ready;
    logic [4*DIGITS-1:0]   bcd_output;
    logic                  overflow;
    logic                  valid;
`ifdef BCD_SIGNED_EN
    logic                  signo_output;
`endif

    modport master (
        output start, numero_input,
        input  ready, bcd_output, overflow, valid
`ifdef BCD_SIGNED_EN
        , input signo_output
`endif
    );

    modport slave (
        input  start, numero_input,
        output ready, bcd_output, overflow, valid
`ifdef BCD_SIGNED_EN
        , output signo_output
`endif
    );
endinterface

// File: rtl/bin_a_bcd_param.sv
// rtl/bin_a_bcd_param.sv - sequential double-dabble binary-to-BCD converter, one bit per clock; BCD_SIGNED_EN adds two's-complement input
module bin_a_bcd_param #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    bin_a_bcd_param_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] bin_sh;
    logic [BW-1:0]    bcd_sh;
    logic             ovf_sticky;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    bcd_next;
    logic [WIDTH-1:0] bin_next;
    logic             carry;
`ifdef BCD_SIGNED_EN
    logic             signo_sh;
`endif

`ifdef BCD_SIGNED_EN
    // Magnitude stays WIDTH bits wide, so the most negative value maps to 2^(WIDTH-1).
    assign mag = bus.numero_input[WIDTH-1] ? -bus.numero_input : bus.numero_input;
`else
    assign mag = bus.numero_input;
`endif

    always_comb begin
        adj = bcd_sh;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        {carry, bcd_next, bin_next} = {adj, bin_sh, 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.ready      <= 1'b1;
            bus.valid      <= 1'b0;
            bus.bcd_output <= '0;
            bus.overflow   <= 1'b0;
            bin_sh         <= '0;
            bcd_sh         <= '0;
            ovf_sticky     <= 1'b0;
            cnt            <= '0;
`ifdef BCD_SIGNED_EN
            signo_sh         <= 1'b0;
            bus.signo_output <= 1'b0;
`endif
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_sh     <= mag;
                        bcd_sh     <= '0;
                        ovf_sticky <= 1'b0;
                        cnt        <= CW'(WIDTH);
                        bus.ready  <= 1'b0;
                        state      <= SHIFT;
`ifdef BCD_SIGNED_EN
                        signo_sh   <= bus.numero_input[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    bcd_sh     <= bcd_next;
                    bin_sh     <= bin_next;
                    ovf_sticky <= ovf_sticky | carry;
                    cnt        <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= DONE;
                end
                DONE: begin
                    bus.bcd_output <= bcd_sh;
                    bus.overflow   <= ovf_sticky;
                    bus.valid      <= 1'b1;
                    bus.ready      <= 1'b1;
                    state          <= IDLE;
`ifdef BCD_SIGNED_EN
                    bus.signo_output <= signo_sh;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
